// File: rtl/cache_fill_arbiter.sv
// cache_fill_arbiter: arbitrates NUM_CH cache miss channels and one write-through
// store port onto a single pipelined memory. A granted miss issues a block-sized
// burst of word reads; returned words stream back to the owning channel with a
// per-word valid and a done pulse on the last word of the block.
// Build option: CACHE_FILL_ROUND_ROBIN_EN selects round-robin miss grant
// (default: fixed priority, lowest channel index wins).
module cache_fill_arbiter #(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16,
    parameter int NUM_CH      = 2,
    parameter int BLOCK_WORDS = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_CH-1:0]        miss_req,
    input  logic [NUM_CH*ADDR_W-1:0] miss_addr,
    output logic [NUM_CH-1:0]        fill_valid,
    output logic [NUM_CH-1:0]        fill_done,
    output logic [DATA_W-1:0]        fill_data,
    output logic [ADDR_W-1:0]        fill_addr,
    input  logic                     wr_req,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    output logic                     wr_ack,
    output logic                     mem_en,
    output logic                     mem_wr,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [DATA_W-1:0]        mem_wdata,
    input  logic [DATA_W-1:0]        mem_rdata,
    input  logic                     mem_rvalid,
    output logic                     busy
);
    localparam int CNT_W = $clog2(BLOCK_WORDS);
    localparam int OFF_W = CNT_W + 1;                 // byte offset bits within a block
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [ADDR_W-1:0] BLK_MASK = ~ADDR_W'((1 << OFF_W) - 1);

    typedef enum logic [1:0] {IDLE, WRITE, ISSUE, DRAIN} state_t;

    state_t              state_q, state_d;
    logic [CH_W-1:0]     ch_q, ch_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [CNT_W-1:0]    issue_cnt_q, issue_cnt_d;
    logic [CNT_W-1:0]    ret_cnt_q, ret_cnt_d;

    logic [NUM_CH-1:0]   fill_valid_q, fill_valid_d;
    logic [NUM_CH-1:0]   fill_done_q, fill_done_d;
    logic [DATA_W-1:0]   fill_data_q, fill_data_d;
    logic [ADDR_W-1:0]   fill_addr_q, fill_addr_d;
    logic                wr_ack_q, wr_ack_d;
    logic                mem_en_q, mem_en_d;
    logic                mem_wr_q, mem_wr_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic                busy_q;

    logic                gnt_vld;
    logic [CH_W-1:0]     gnt_ch;
    logic [ADDR_W-1:0]   gnt_addr;

`ifdef CACHE_FILL_ROUND_ROBIN_EN
    logic [CH_W-1:0]     rr_q, rr_d;

    // Round-robin grant: first requester at or after the pointer wins.
    always_comb begin
        int idx;
        idx      = 0;
        gnt_vld  = 1'b0;
        gnt_ch   = '0;
        gnt_addr = '0;
        // Descending scan so the smallest offset from the pointer overwrites last.
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            idx = (int'(rr_q) + k) % NUM_CH;
            if (miss_req[idx]) begin
                gnt_vld  = 1'b1;
                gnt_ch   = CH_W'(idx);
                gnt_addr = miss_addr[idx*ADDR_W +: ADDR_W];
            end
        end
    end
`else
    // Fixed-priority grant: lowest-index requester wins.
    always_comb begin
        gnt_vld  = 1'b0;
        gnt_ch   = '0;
        gnt_addr = '0;
        for (int c = NUM_CH - 1; c >= 0; c--) begin
            if (miss_req[c]) begin
                gnt_vld  = 1'b1;
                gnt_ch   = CH_W'(c);
                gnt_addr = miss_addr[c*ADDR_W +: ADDR_W];
            end
        end
    end
`endif

    // Next-state and registered-output decode; outputs are loaded on the edge
    // that enters a state so they line up with that state's cycles.
    always_comb begin
        state_d      = state_q;
        ch_d         = ch_q;
        base_d       = base_q;
        issue_cnt_d  = issue_cnt_q;
        ret_cnt_d    = ret_cnt_q;
        fill_valid_d = '0;
        fill_done_d  = '0;
        fill_data_d  = '0;
        fill_addr_d  = '0;
        wr_ack_d     = 1'b0;
        mem_en_d     = 1'b0;
        mem_wr_d     = 1'b0;
        mem_addr_d   = '0;
        mem_wdata_d  = '0;
`ifdef CACHE_FILL_ROUND_ROBIN_EN
        rr_d         = rr_q;
`endif
        case (state_q)
            IDLE: begin
                // Stores first, so a fill that follows reads the stored data.
                if (wr_req) begin
                    state_d     = WRITE;
                    wr_ack_d    = 1'b1;
                    mem_en_d    = 1'b1;
                    mem_wr_d    = 1'b1;
                    mem_addr_d  = wr_addr;
                    mem_wdata_d = wr_data;
                end else if (gnt_vld) begin
                    state_d     = ISSUE;
                    ch_d        = gnt_ch;
                    base_d      = gnt_addr & BLK_MASK;
                    issue_cnt_d = '0;
                    ret_cnt_d   = '0;
                    mem_en_d    = 1'b1;
                    mem_addr_d  = gnt_addr & BLK_MASK;
                end
            end
            WRITE: state_d = IDLE;
            ISSUE: begin
                // issue_cnt_q is the index of the word currently on the bus.
                if (issue_cnt_q == CNT_W'(BLOCK_WORDS - 1)) begin
                    state_d = DRAIN;
                end else begin
                    issue_cnt_d = issue_cnt_q + 1'b1;
                    mem_en_d    = 1'b1;
                    mem_addr_d  = base_q + ADDR_W'({issue_cnt_d, 1'b0});
                end
            end
            DRAIN: ;
            default: state_d = IDLE;
        endcase

        // Returns are only accepted while a fill owns the port; anything else is stale.
        if ((state_q == ISSUE || state_q == DRAIN) && mem_rvalid) begin
            fill_valid_d[ch_q] = 1'b1;
            fill_data_d        = mem_rdata;
            fill_addr_d        = base_q + ADDR_W'({ret_cnt_q, 1'b0});
            ret_cnt_d          = ret_cnt_q + 1'b1;
            if (ret_cnt_q == CNT_W'(BLOCK_WORDS - 1)) begin
                fill_done_d[ch_q] = 1'b1;
                state_d           = IDLE;
                mem_en_d          = 1'b0;
                mem_addr_d        = '0;
`ifdef CACHE_FILL_ROUND_ROBIN_EN
                rr_d = (ch_q == CH_W'(NUM_CH - 1)) ? '0 : ch_q + 1'b1;
`endif
            end
        end
    end

    // State, bookkeeping and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            ch_q         <= '0;
            base_q       <= '0;
            issue_cnt_q  <= '0;
            ret_cnt_q    <= '0;
            fill_valid_q <= '0;
            fill_done_q  <= '0;
            fill_data_q  <= '0;
            fill_addr_q  <= '0;
            wr_ack_q     <= 1'b0;
            mem_en_q     <= 1'b0;
            mem_wr_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            busy_q       <= 1'b0;
`ifdef CACHE_FILL_ROUND_ROBIN_EN
            rr_q         <= '0;
`endif
        end else begin
            state_q      <= state_d;
            ch_q         <= ch_d;
            base_q       <= base_d;
            issue_cnt_q  <= issue_cnt_d;
            ret_cnt_q    <= ret_cnt_d;
            fill_valid_q <= fill_valid_d;
            fill_done_q  <= fill_done_d;
            fill_data_q  <= fill_data_d;
            fill_addr_q  <= fill_addr_d;
            wr_ack_q     <= wr_ack_d;
            mem_en_q     <= mem_en_d;
            mem_wr_q     <= mem_wr_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            // Registered copy of the current state, so busy drops the cycle after fill_done.
            busy_q       <= (state_q != IDLE);
`ifdef CACHE_FILL_ROUND_ROBIN_EN
            rr_q         <= rr_d;
`endif
        end
    end

    assign fill_valid = fill_valid_q;
    assign fill_done  = fill_done_q;
    assign fill_data  = fill_data_q;
    assign fill_addr  = fill_addr_q;
    assign wr_ack     = wr_ack_q;
    assign mem_en     = mem_en_q;
    assign mem_wr     = mem_wr_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_cache_fill_arbiter.sv
// Directed bench for cache_fill_arbiter: reset, contention, single fill,
// store priority, address wrap and reset during drain. Memory model returns
// addr ^ 16'hFFFF after a programmable number of cycles.
module tb_cache_fill_arbiter;
    logic        clk;
    logic        rst_n;
    logic [1:0]  miss_req;
    logic [31:0] miss_addr;
    logic [1:0]  fill_valid;
    logic [1:0]  fill_done;
    logic [15:0] fill_data;
    logic [15:0] fill_addr;
    logic        wr_req;
    logic [15:0] wr_addr;
    logic [15:0] wr_data;
    logic        wr_ack;
    logic        mem_en;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_rvalid;
    logic        busy;

    int n_chk  = 0;
    int n_fail = 0;
    int lat;
    logic force_rv;

    logic [7:0]       pv = '0;
    logic [7:0][15:0] pd = '0;

    cache_fill_arbiter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .miss_req   (miss_req),
        .miss_addr  (miss_addr),
        .fill_valid (fill_valid),
        .fill_done  (fill_done),
        .fill_data  (fill_data),
        .fill_addr  (fill_addr),
        .wr_req     (wr_req),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_ack     (wr_ack),
        .mem_en     (mem_en),
        .mem_wr     (mem_wr),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_rvalid (mem_rvalid),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pipelined memory: each read issue reappears lat cycles later.
    always @(posedge clk) begin
        pv <= {pv[6:0], mem_en & ~mem_wr};
        pd <= {pd[6:0], mem_addr ^ 16'hFFFF};
    end
    assign mem_rvalid = pv[lat-1] | force_rv;
    assign mem_rdata  = pd[lat-1];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    // Follow one block fill from its first read issue to its done beat.
    task automatic do_fill(input int ch, input logic [15:0] base, input logic [1:0] req_after,
                           input bit chk_idle, input int wr_at);
        int icnt;
        int bcnt;
        bit ok;
        logic [15:0] ea;
        ok = 1'b0;
        for (int t = 0; t < 50; t++) begin
            if (mem_en && !mem_wr) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("issue_seen", 32'(ok), 32'd1);
        if (!ok) return;
        icnt = 0;
        bcnt = 0;
        for (int t = 0; t < 60 && bcnt < 8; t++) begin
            if (t == wr_at) begin
                wr_req  = 1'b1;
                wr_addr = 16'h0AB2;
                wr_data = 16'hC3C3;
            end
            if (wr_at >= 0) chk("no_ack_mid_fill", 32'(wr_ack), 32'd0);
            if (icnt < 8) begin
                chk("rd_cmd", 32'({mem_en, mem_wr}), 32'd2);
                chk("rd_addr", 32'(mem_addr), 32'(base + 16'(2 * icnt)));
                icnt++;
            end
            if (fill_valid != 2'b00) begin
                ea = base + 16'(2 * bcnt);
                chk("fill_valid", 32'(fill_valid), 32'(1 << ch));
                chk("fill_addr", 32'(fill_addr), 32'(ea));
                chk("fill_data", 32'(fill_data), 32'(ea ^ 16'hFFFF));
                chk("fill_done", 32'(fill_done), (bcnt == 7) ? 32'(1 << ch) : 32'd0);
                bcnt++;
                if (bcnt == 8) begin
                    chk("busy_at_done", 32'(busy), 32'd1);
                    miss_req = req_after;
                end
            end
            if (bcnt < 8) @(negedge clk);
        end
        chk("beat_count", 32'(bcnt), 32'd8);
        if (chk_idle) begin
            @(negedge clk);
            chk("busy_after_done", 32'(busy), 32'd0);
            chk("idle_mem_en", 32'(mem_en), 32'd0);
        end
    endtask

    initial begin
        int bcnt;
        bit ok;
        rst_n     = 1'b0;
        miss_req  = 2'b11;
        miss_addr = {16'h020C, 16'h0106};
        wr_req    = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        force_rv  = 1'b1;
        lat       = 4;

        // Reset with requests and returns active: everything quiet.
        repeat (10) @(negedge clk);
        chk("rst_fill_valid", 32'(fill_valid), 32'd0);
        chk("rst_fill_done", 32'(fill_done), 32'd0);
        chk("rst_fill_data", 32'(fill_data), 32'd0);
        chk("rst_fill_addr", 32'(fill_addr), 32'd0);
        chk("rst_wr_ack", 32'(wr_ack), 32'd0);
        chk("rst_mem_cmd", 32'({mem_en, mem_wr}), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        force_rv = 1'b0;
        rst_n    = 1'b1;

        // Contention: both channels held high; first grant is ch0.
        do_fill(0, 16'h0100, 2'b11, 1'b0, -1);
`ifdef CACHE_FILL_ROUND_ROBIN_EN
        do_fill(1, 16'h0200, 2'b11, 1'b0, -1);
`else
        do_fill(0, 16'h0100, 2'b11, 1'b0, -1);
`endif
        do_fill(0, 16'h0100, 2'b00, 1'b1, -1);

        // Single fill on ch1 from an unaligned address.
        miss_addr[31:16] = 16'h123A;
        miss_req         = 2'b10;
        do_fill(1, 16'h1230, 2'b00, 1'b1, -1);

        // Store arrives mid-fill: waits for fill_done, then beats a ch1 miss.
        miss_addr = {16'h0A5E, 16'h0448};
        miss_req  = 2'b01;
        do_fill(0, 16'h0440, 2'b10, 1'b0, 3);
        @(negedge clk);
        chk("wr_cmd", 32'({mem_en, mem_wr}), 32'd3);
        chk("wr_addr", 32'(mem_addr), 32'h0AB2);
        chk("wr_wdata", 32'(mem_wdata), 32'hC3C3);
        chk("wr_ack", 32'(wr_ack), 32'd1);
        wr_req = 1'b0;
        @(negedge clk);
        chk("wr_ack_pulse", 32'(wr_ack), 32'd0);
        chk("post_wr_idle", 32'(mem_en), 32'd0);
        do_fill(1, 16'h0A50, 2'b00, 1'b1, -1);

        // Address wrap at the top of the space.
        miss_addr[15:0] = 16'hFFF4;
        miss_req        = 2'b01;
        do_fill(0, 16'hFFF0, 2'b00, 1'b1, -1);

        // Reset during DRAIN after three returns; the other five must vanish.
        repeat (10) @(negedge clk);
        lat             = 6;
        miss_addr[15:0] = 16'h2000;
        miss_req        = 2'b01;
        ok = 1'b0;
        for (int t = 0; t < 50; t++) begin
            if (mem_en && !mem_wr) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("drain_issue_seen", 32'(ok), 32'd1);
        bcnt = 0;
        for (int t = 0; t < 40 && bcnt < 3; t++) begin
            if (fill_valid != 2'b00) bcnt++;
            if (bcnt < 3) @(negedge clk);
        end
        chk("drain_beats", 32'(bcnt), 32'd3);
        chk("drain_mem_en", 32'(mem_en), 32'd0);
        chk("drain_busy", 32'(busy), 32'd1);
        rst_n    = 1'b0;
        miss_req = 2'b00;
        @(negedge clk);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_fv", 32'(fill_valid), 32'd0);
        rst_n = 1'b1;
        for (int t = 0; t < 8; t++) begin
            @(negedge clk);
            chk("stale_fv", 32'(fill_valid), 32'd0);
        end
        repeat (4) @(negedge clk);
        lat              = 4;
        miss_addr[31:16] = 16'h3456;
        miss_req         = 2'b10;
        do_fill(1, 16'h3450, 2'b00, 1'b1, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/cache_fill_arbiter.md
Name: cache_fill_arbiter

Overview:
- Parametrised successor to the single-port RAM controller; sits between NUM_CH cache miss channels (I-cache, D-cache, ...) and one pipelined unified memory.
- Arbitrates pending misses, issues a block-sized burst of word reads, and streams returned words back to the owning cache with per-word valid and a done pulse.
- Also arbitrates single-word write-through stores from the D-cache onto the same memory port.

Parameters:
- ADDR_W, 16, byte address width
- DATA_W, 16, word width (2 bytes/word)
- NUM_CH, 2, number of miss channels (ch0 = I-cache, ch1 = D-cache)
- BLOCK_WORDS, 8, words per cache block (power of 2, >=2)

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- miss_req  in  NUM_CH  per-channel miss request; held high until that channel's fill_done
- miss_addr  in  NUM_CH*ADDR_W  per-channel miss byte address; channel c at bits [c*ADDR_W +: ADDR_W]
- fill_valid  out  NUM_CH  one-hot; fill_data/fill_addr valid for that channel this cycle
- fill_done  out  NUM_CH  one-hot pulse with the last fill_valid of a block
- fill_data  out  DATA_W  returned word (shared by all channels)
- fill_addr  out  ADDR_W  byte address of fill_data
- wr_req  in  1  store request; held until wr_ack
- wr_addr  in  ADDR_W  store byte address
- wr_data  in  DATA_W  store data
- wr_ack  out  1  one-cycle pulse: store issued to memory
- mem_en  out  1  memory access strobe
- mem_wr  out  1  1 = write, 0 = read
- mem_addr  out  ADDR_W  memory byte address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data
- mem_rvalid  in  1  mem_rdata valid; reads return in issue order, fixed but unknown latency >=1
- busy  out  1  state != IDLE

Behaviour:
- Reset (rst_n low at clk edge): state IDLE; all outputs 0; counters, latched channel and base cleared.
- States: IDLE, WRITE, ISSUE, DRAIN. All outputs are registered.
- IDLE, wr_req=1:
  - Go to WRITE. Stores take priority over misses so a later fill reads fresh data.
- IDLE, wr_req=0 and any miss_req:
  - Grant the lowest-index requester.
  - Latch ch and base = miss_addr[ch] with the low log2(BLOCK_WORDS)+1 bits cleared.
  - Go to ISSUE with issue_cnt = ret_cnt = 0.
- WRITE (1 cycle):
  - mem_en=1, mem_wr=1, mem_addr=wr_addr, mem_wdata=wr_data, wr_ack=1.
  - Next state IDLE, so back-to-back stores issue every 2 cycles.
- ISSUE:
  - Each cycle: mem_en=1, mem_wr=0, mem_addr=base+2*issue_cnt; issue_cnt increments.
  - After BLOCK_WORDS cycles, go to DRAIN. If returns already total BLOCK_WORDS, go straight to IDLE.
- Returns (ISSUE or DRAIN), on each mem_rvalid:
  - Next cycle: fill_valid[ch]=1, fill_data=mem_rdata, fill_addr=base+2*ret_cnt; ret_cnt increments.
  - The return with ret_cnt=BLOCK_WORDS-1 also sets fill_done[ch]=1, and the state goes to IDLE.
- DRAIN: mem_en=0; wait for remaining returns.
- Address arithmetic wraps modulo 2^ADDR_W. A block always starts aligned, so issue addresses never cross the block.
- mem_rvalid in IDLE or WRITE is ignored (stale returns after reset). mem_rvalid beyond BLOCK_WORDS returns is ignored.
- miss_req dropping mid-fill: the fill still completes to the latched channel. miss_addr changes after grant are ignored.
- wr_req arriving during a fill waits until IDLE. A requester still high after its fill_done is re-granted from IDLE (min 1-cycle gap).
- Minimum miss-to-done latency: 1 (grant) + BLOCK_WORDS + mem latency cycles.

Optional Feature:
- Macro: CACHE_FILL_ROUND_ROBIN_EN.
- Defined: miss grant is round-robin. After a fill for channel c completes, search starts at (c+1) mod NUM_CH. The pointer resets to 0. Store priority is unchanged.
- Undefined: fixed priority, lowest index wins.

Test Plan:
- Reset: hold rst_n=0 with miss_req=2'b11 and mem_rvalid=1 -> all outputs 0, busy=0; after release, the first grant goes to ch0.
- Single fill, ch1: miss_addr[1]=16'h123A, memory latency 4 returning addr^16'hFFFF.
  - mem_addr runs 1230,1232,...,123E on consecutive cycles.
  - Eight fill_valid=2'b10 beats carry matching addr/data; fill_done=2'b10 on the 8th beat; busy falls the next cycle.
- Contention: miss_req=2'b11 continuously.
  - Fixed priority: ch0 is re-granted every time.
  - With CACHE_FILL_ROUND_ROBIN_EN: grants alternate 0,1,0,1.
- Store priority: wr_req asserted mid-fill of ch0.
  - wr_ack waits for fill_done. Then with wr_req and miss_req[1] both high in IDLE, the WRITE (mem_wr=1, addr/data exact) precedes the ch1 burst.
- Address wrap: miss_addr=16'hFFF4 -> burst addresses FFF0..FFFE, no carry beyond 16 bits.
- Reset mid-DRAIN after 3 returns: state IDLE, the remaining 5 mem_rvalid pulses produce no fill_valid, and a new miss then fills correctly.
